// File: rtl/tl45_pipe_ctrl.sv
// TL45 issue/hazard controller: per-register in-flight write scoreboard,
// branch flush sequencing and pipeline drain handshake.
module tl45_pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_dec_valid,
   input  logic [3:0]  i_dec_dr,
   input  logic [3:0]  i_dec_sr1,
   input  logic [3:0]  i_dec_sr2,
   input  logic        i_dec_wr,
   input  logic        i_alu_busy,
   input  logic        i_br_taken,
   input  logic        i_wb_valid,
   input  logic [3:0]  i_wb_dr,
   input  logic        i_drain_req,
   output logic        o_dec_stall,
   output logic        o_issue,
   output logic        o_flush,
   output logic        o_drain_ack,
   output logic [15:0] o_busy_mask,
   output logic        o_sb_err
);

   localparam int unsigned NREG  = 16;
   localparam int unsigned FCW   = 3;
   localparam logic [FCW-1:0] FLOAD = FCW'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_t;

   state_t             r_state, w_state_nxt;
   logic [FCW-1:0]     r_fcnt, w_fcnt_nxt;
   logic [CNT_W-1:0]   r_cnt [NREG];
   logic               r_err;

   logic [NREG-1:0]    w_zero;
   logic [NREG-1:0]    w_inc;
   logic [NREG-1:0]    w_dec;
   logic               w_all_zero;
   logic               w_hazard;
   logic               w_run_ok;
   logic               w_flush;
   logic               w_ack;
   logic               w_issue;
   logic               w_err_set;

   // Entry 0 is never incremented or decremented, so it reads as zero forever.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         w_zero[i] = (r_cnt[i] == '0);
      end
   end

   assign w_all_zero = &w_zero;

   assign w_hazard = i_dec_valid &&
                     (!w_zero[i_dec_sr1] || !w_zero[i_dec_sr2] ||
                      (i_dec_wr && (i_dec_dr != 4'd0) && (r_cnt[i_dec_dr] == '1)) ||
                      i_alu_busy);

   // Flush/drain state machine; a taken branch always wins over drain.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_flush     = 1'b0;
      w_ack       = 1'b0;
      w_run_ok    = 1'b0;
      case (r_state)
         S_RUN: begin
            if (i_br_taken) begin
               w_flush     = 1'b1;
               w_fcnt_nxt  = FLOAD;
               w_state_nxt = (FLOAD != '0) ? S_FLUSH : S_RUN;
            end else if (i_drain_req) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_run_ok    = 1'b1;
            end
         end
         S_FLUSH: begin
            w_flush = 1'b1;
            if (i_br_taken) begin
               w_fcnt_nxt  = FLOAD;
               w_state_nxt = (FLOAD != '0) ? S_FLUSH : S_RUN;
            end else if (r_fcnt <= FCW'(1)) begin
               w_fcnt_nxt  = '0;
               w_state_nxt = S_RUN;
            end else begin
               w_fcnt_nxt  = r_fcnt - FCW'(1);
            end
         end
         S_DRAIN: begin
            if (i_br_taken) begin
               w_flush     = 1'b1;
               w_fcnt_nxt  = FLOAD;
               w_state_nxt = (FLOAD != '0) ? S_FLUSH : S_RUN;
            end else if (w_all_zero && !i_alu_busy) begin
               w_ack       = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_RUN;
            w_fcnt_nxt  = '0;
         end
      endcase
   end

   assign w_issue = !i_reset && w_run_ok && i_dec_valid && !w_hazard;

   assign w_inc = (w_issue && i_dec_wr && (i_dec_dr != 4'd0)) ?
                  (NREG'(1) << i_dec_dr) : '0;
   assign w_dec = (i_wb_valid && (i_wb_dr != 4'd0)) ?
                  (NREG'(1) << i_wb_dr) : '0;

   // A writeback to an idle register is a scoreboard underflow.
   assign w_err_set = |(w_dec & ~w_inc & w_zero);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_RUN;
         r_fcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_err   <= r_err | w_err_set;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (w_dec[i] && !w_inc[i] && !w_zero[i]) begin
               r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
         end
      end
   end

   assign o_issue     = w_issue;
   assign o_flush     = !i_reset && w_flush;
   assign o_drain_ack = !i_reset && w_ack;
   assign o_dec_stall = !i_reset && i_dec_valid && !w_issue && !w_flush;
   assign o_busy_mask = i_reset ? '0 : ~w_zero;
   assign o_sb_err    = r_err;

endmodule

// File: tb/tb_tl45_pipe_ctrl.sv
// Directed-vector bench for tl45_pipe_ctrl; per-cycle expected outputs are
// queued by the driver and compared by an independent negedge monitor.
module tb_tl45_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic [3:0]  dec_dr, dec_sr1, dec_sr2;
   logic        dec_wr, alu_busy, br_taken, wb_valid, drain_req;
   logic [3:0]  wb_dr;
   logic        dec_stall, issue, flush, drain_ack, sb_err;
   logic [15:0] busy_mask;

   typedef struct {
      int issue;
      int stall;
      int flush;
      int ack;
      int mask;
      int err;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   failures;
   bit   done;

   tl45_pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_dec_valid (dec_valid),
      .i_dec_dr    (dec_dr),
      .i_dec_sr1   (dec_sr1),
      .i_dec_sr2   (dec_sr2),
      .i_dec_wr    (dec_wr),
      .i_alu_busy  (alu_busy),
      .i_br_taken  (br_taken),
      .i_wb_valid  (wb_valid),
      .i_wb_dr     (wb_dr),
      .i_drain_req (drain_req),
      .o_dec_stall (dec_stall),
      .o_issue     (issue),
      .o_flush     (flush),
      .o_drain_ack (drain_ack),
      .o_busy_mask (busy_mask),
      .o_sb_err    (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int vec, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, vec, act, req);
      end
   endtask

   // Monitor: one expected record is consumed per cycle that the driver issued.
   int vec_no = 0;
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("issue", vec_no, int'(issue),     e.issue);
         chk("stall", vec_no, int'(dec_stall), e.stall);
         chk("flush", vec_no, int'(flush),     e.flush);
         chk("ack",   vec_no, int'(drain_ack), e.ack);
         chk("mask",  vec_no, int'(busy_mask), e.mask);
         chk("err",   vec_no, int'(sb_err),    e.err);
         vec_no++;
      end
   end

   // One cycle of stimulus: inputs applied just after the rising edge.
   task automatic step(input int v, input int dr, input int s1, input int s2,
                       input int wr, input int busy, input int br, input int wbv,
                       input int wbd, input int drn, input int rs,
                       input int ei, input int es, input int ef, input int ea,
                       input int em, input int ee);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = 1'(rs);
      dec_valid = 1'(v);
      dec_dr    = 4'(dr);
      dec_sr1   = 4'(s1);
      dec_sr2   = 4'(s2);
      dec_wr    = 1'(wr);
      alu_busy  = 1'(busy);
      br_taken  = 1'(br);
      wb_valid  = 1'(wbv);
      wb_dr     = 4'(wbd);
      drain_req = 1'(drn);
      e.issue = ei; e.stall = es; e.flush = ef; e.ack = ea; e.mask = em; e.err = ee;
      q.push_back(e);
   endtask

   initial begin
      checks = 0; failures = 0; done = 1'b0;
      rst = 1'b1; dec_valid = 1'b0; dec_dr = '0; dec_sr1 = '0; dec_sr2 = '0;
      dec_wr = 1'b0; alu_busy = 1'b0; br_taken = 1'b0; wb_valid = 1'b0;
      wb_dr = '0; drain_req = 1'b0;

      //    v dr s1 s2 wr bz br wv wd dn rs   iss stl fl ack mask    err
      // Reset overrides active inputs
      step(1, 3, 3, 0, 1, 1, 1, 1, 9, 1, 1,  0, 0, 0, 0, 16'h0000, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16'h0000, 0);
      // RAW hazard on r3
      step(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0008, 0);
      step(1, 0, 3, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1, 0, 0, 16'h0008, 0);
      step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      // Counter saturation on r5
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 0);
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 0);
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0020, 0);
      step(1, 5, 0, 0, 1, 0, 0, 1, 5, 0, 0,  0, 1, 0, 0, 16'h0020, 0);
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0020, 0);
      step(1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0020, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 16'h0020, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 16'h0020, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 0, 16'h0020, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16'h0000, 0);
      // Branch flush: two cycles
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      // Second branch inside flush extends by one
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      // Drain with two writes to r7 in flight
      step(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      step(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0080, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 16'h0080, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0,  0, 1, 0, 0, 16'h0080, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  0, 1, 0, 0, 16'h0080, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 16'h0000, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      // Underflow on r9 sets sticky error; r0 writes are untracked
      step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  0, 0, 0, 0, 16'h0000, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16'h0000, 1);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1);
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1);
      // ALU busy stalls
      step(1, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 16'h0000, 1);
      // Reset mid-flush with r4 in flight
      step(1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 16'h0010, 1);
      step(1, 0, 4, 0, 0, 0, 1, 0, 0, 1, 1,  0, 0, 0, 0, 16'h0000, 0);
      step(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      // Same-cycle issue and writeback of an idle register
      step(1, 6, 0, 0, 1, 0, 0, 1, 6, 0, 0,  1, 0, 0, 0, 16'h0000, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16'h0000, 0);

      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
